handshake_master_fifo: RTL and testbench

Parametrised valid/ready source for the AXI4 handshake path. It accepts write strobes from local logic into a DEPTH-entry FIFO and presents the entries to a downstream slave under valid/ready rules. `data_out` holds stable while `valid` is high and `ready` is low. It also provides backpressure, overflow detection and a transfer counter. It replaces the single-register master wherever the producer cannot stall on `ready`.

---
 rtl/handshake_pkg.sv | 15 +
 rtl/handshake_fifo_mem.sv | 28 ++
 rtl/handshake_master_fifo.sv | 90 +++++++++
 tb/tb_handshake_master_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared defaults and helpers for the handshake master FIFO slice.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package handshake_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_CNT_W  = 16;

    // Occupancy runs 0..DEPTH inclusive, so it needs one bit beyond the pointer.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one asynchronous read port.
// Latency: a write lands at the clock edge; the read is combinational from raddr.
// Backpressure: none here; the caller gates we.
module handshake_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately left unreset; occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_master_fifo.sv
// Valid/ready source fed by a DEPTH-entry FIFO, with an overflow flag and a transfer counter.
// Latency: a write into an empty FIFO is presented on data_out/valid in the following cycle.
// Backpressure: in_ready drops when full; a write while full is dropped and sets sticky overflow.
module handshake_master_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DATA_W-1:0]       data_in,
    output logic                    in_ready,
    output logic                    valid,
    input  logic                    ready,
    output logic [DATA_W-1:0]       data_out,
    output logic [lvl_w(DEPTH)-1:0] level,
    output logic                    overflow,
    output logic [CNT_W-1:0]        xfer_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [DATA_W-1:0] rdata;
    logic              push;
    logic              pop;

    // Flags come from registered level only, so neither ready nor en reaches them combinationally.
    assign valid    = (level != '0);
    assign in_ready = (level != FULL_LVL);
    assign push     = en && in_ready;
    assign pop      = valid && ready;

    // Masking with valid keeps data_out at zero out of reset while storage is still unknown.
    assign data_out = valid ? rdata : '0;

    handshake_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (data_in),
        .raddr (rptr),
        .rdata (rdata)
    );

    // Pointers wrap naturally; full/empty are decoded from level, never from pointer compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
        end
    end

    // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Overflow is sticky until reset; the completed-transfer counter wraps freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            if (en && !in_ready) overflow <= 1'b1;
            if (pop)             xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_handshake_master_fifo.sv
// Directed bench for handshake_master_fifo, with a second narrow-counter instance for wrap.
// Latency: inputs change 1 ns after the rising edge; outputs are sampled at that point.
// Backpressure: exercised through ready-low holds, fill-to-full and full-with-pop.
module tb_handshake_master_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] data_in = '0;
    logic        ready = 1'b0;
    logic        in_ready, valid, overflow;
    logic [31:0] data_out;
    logic [2:0]  level;
    logic [15:0] xfer_cnt;

    logic        s_in_ready, s_valid, s_overflow;
    logic [31:0] s_data_out;
    logic [2:0]  s_level;
    logic [3:0]  s_xfer_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    handshake_master_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .in_ready (in_ready),
        .valid    (valid),
        .ready    (ready),
        .data_out (data_out),
        .level    (level),
        .overflow (overflow),
        .xfer_cnt (xfer_cnt)
    );

    handshake_master_fifo #(.CNT_W(4)) dut_w4 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .in_ready (s_in_ready),
        .valid    (s_valid),
        .ready    (ready),
        .data_out (s_data_out),
        .level    (s_level),
        .overflow (s_overflow),
        .xfer_cnt (s_xfer_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0;
        ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL reset_xfer_cnt got=%0d exp=0", xfer_cnt); end
        checks++; if (data_out !== 32'd0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    endtask

    task automatic test_single_word();
        en = 1'b1;
        data_in = 32'hA5A5_0001;
        ready = 1'b0;
        tick();
        en = 1'b0;
        data_in = 32'hDEAD_BEEF;
        checks++; if (valid !== 1'b1 || level !== 3'd1) begin failures++; $display("FAIL single_valid got=%0b/%0d exp=1/1", valid, level); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid !== 1'b1 || data_out !== 32'hA5A5_0001) begin
                failures++; $display("FAIL single_hold cyc=%0d got=%0b/%h exp=1/a5a50001", i, valid, data_out);
            end
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL single_pop got=%0b/%0d exp=0/0", valid, level); end
        checks++; if (xfer_cnt !== 16'd1) begin failures++; $display("FAIL single_xfer got=%0d exp=1", xfer_cnt); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            en = 1'b1;
            data_in = i;
            tick();
        end
        en = 1'b0;
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL fill_level got=%0d exp=4", level); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%0b exp=1", overflow); end
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (valid !== 1'b1 || data_out !== 32'(i)) begin
                failures++; $display("FAIL drain_word got=%0b/%0d exp=1/%0d", valid, data_out, i);
            end
            tick();
        end
        ready = 1'b0;
        checks++; if (valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL drain_empty got=%0b/%0d exp=0/0", valid, level); end
        checks++; if (xfer_cnt !== 16'd4) begin failures++; $display("FAIL drain_xfer got=%0d exp=4", xfer_cnt); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            en = 1'b1;
            data_in = 32'h10 + i;
            tick();
        end
        checks++; if (level !== 3'd4 || overflow !== 1'b0) begin failures++; $display("FAIL fullpop_pre got=%0d/%0b exp=4/0", level, overflow); end
        en = 1'b1;
        ready = 1'b1;
        data_in = 32'h99;
        tick();
        en = 1'b0;
        ready = 1'b0;
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL fullpop_level got=%0d exp=3", level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fullpop_overflow got=%0b exp=1", overflow); end
        checks++; if (xfer_cnt !== 16'd1) begin failures++; $display("FAIL fullpop_xfer got=%0d exp=1", xfer_cnt); end
        ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            checks++;
            if (valid !== 1'b1 || data_out !== 32'h10 + 32'(i)) begin
                failures++; $display("FAIL fullpop_drain got=%0b/%h exp=1/%h", valid, data_out, 32'h10 + i);
            end
            tick();
        end
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL fullpop_dropped got=%0b exp=0", valid); end
    endtask

    task automatic test_streaming();
        int rx;
        int max_lvl;
        do_reset();
        rx = 0;
        max_lvl = 0;
        ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            en = 1'b1;
            data_in = i;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (valid) begin
                checks++;
                if (data_out !== 32'(rx)) begin failures++; $display("FAIL stream_order got=%0d exp=%0d", data_out, rx); end
                rx++;
            end
            tick();
        end
        en = 1'b0;
        for (int k = 0; k < 4 && valid; k++) begin
            checks++;
            if (data_out !== 32'(rx)) begin failures++; $display("FAIL stream_tail got=%0d exp=%0d", data_out, rx); end
            rx++;
            tick();
        end
        ready = 1'b0;
        checks++; if (rx != 100) begin failures++; $display("FAIL stream_count got=%0d exp=100", rx); end
        checks++; if (max_lvl > 1) begin failures++; $display("FAIL stream_level got=%0d exp<=1", max_lvl); end
        checks++; if (xfer_cnt !== 16'd100) begin failures++; $display("FAIL stream_xfer got=%0d exp=100", xfer_cnt); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL stream_overflow got=%0b exp=0", overflow); end
    endtask

    task automatic test_reset_mid_and_wrap();
        int pushes;
        int pops;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            en = 1'b1;
            data_in = 32'h55 + i;
            tick();
        end
        en = 1'b0;
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL mid_pre_level got=%0d exp=3", level); end
        rst = 1'b1;
        #1;
        checks++; if (valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL mid_async got=%0b/%0d exp=0/0", valid, level); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%0b exp=1", in_ready); end
        tick();
        rst = 1'b0;
        tick();
        pushes = 0;
        pops = 0;
        for (int c = 0; c < 40 && pops < 17; c++) begin
            en = (pushes < 17);
            data_in = pushes;
            ready = 1'b1;
            if (en && in_ready) pushes++;
            if (valid) pops++;
            tick();
        end
        en = 1'b0;
        ready = 1'b0;
        checks++; if (pops != 17) begin failures++; $display("FAIL wrap_pops got=%0d exp=17", pops); end
        checks++; if (xfer_cnt !== 16'd17) begin failures++; $display("FAIL wrap_xfer16 got=%0d exp=17", xfer_cnt); end
        checks++; if (s_xfer_cnt !== 4'd1) begin failures++; $display("FAIL wrap_xfer4 got=%0d exp=1", s_xfer_cnt); end
        checks++; if (s_valid !== 1'b0 || s_overflow !== 1'b0) begin failures++; $display("FAIL wrap_w4_state got=%0b/%0b exp=0/0", s_valid, s_overflow); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_overflow();
        test_full_pop();
        test_streaming();
        test_reset_mid_and_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
